data_mem_slave: RTL and testbench

- Word-organised data memory slave sitting directly downstream of the core's load/store memory controller.
- Accepts single-cycle read or write strobes with a word-aligned address, byte enables and pre-shifted write data.
- Waits a configurable number of cycles, performs the access, then returns a one-cycle read_ack or write_ack.
- Used as the default data-side memory model and as the FPGA-synthesisable data RAM.

---
 rtl/mem_pkg.sv | 25 ++
 rtl/mem_array.sv | 35 +++
 rtl/data_mem_slave.sv | 216 +++++++++++++++++++++
 tb/tb_data_mem_slave.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared widths, operation and FSM encodings for the data memory slave.
package mem_pkg;

  localparam int WORD_W = 32;
  localparam int BE_W   = 4;
  localparam int CNT_W  = 4;

  typedef enum logic [1:0] {
    MEM_NONE = 2'd0,
    MEM_RD   = 2'd1,
    MEM_WR   = 2'd2
  } mem_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ACK  = 2'd2
  } slave_state_t;

  // Wait-counter preload for a latency; latency 1 means no WAIT cycles.
  function automatic logic [CNT_W-1:0] lat_load(input int lat);
    return CNT_W'(lat - 1);
  endfunction

endpackage

// File: rtl/mem_array.sv
// Synchronous single-port RAM with per-byte-lane write enables.
// The read register only updates on a read so the last word read is held.
module mem_array
  import mem_pkg::*;
#(
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              re,
  input  logic [BE_W-1:0]   we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [WORD_W-1:0] wdata,
  output logic [WORD_W-1:0] rdata
);

  logic [WORD_W-1:0] mem [DEPTH];

  // Write only the enabled byte lanes of the addressed word.
  always_ff @(posedge clk) begin
    for (int i = 0; i < BE_W; i++) begin
      if (we[i]) begin
        mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  // Registered read, held until the next read.
  always_ff @(posedge clk) begin
    if (re) begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/data_mem_slave.sv
// Word-organised data memory slave: accepts one read or write strobe,
// waits a fixed latency, performs the access and pulses read_ack/write_ack.
module data_mem_slave
  import mem_pkg::*;
#(
  parameter int          DEPTH         = 1024,
  parameter logic [31:0] BASE_ADDR     = 32'h0000_0000,
  parameter int          READ_LATENCY  = 2,
  parameter int          WRITE_LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] address,
  input  logic        read_enable,
  input  logic        write_enable,
  input  logic [3:0]  write_byte_enable,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        read_ack,
  output logic        write_ack,
  output logic        busy,
  output logic        protocol_err,
  output logic        addr_err
);

  localparam int               IDX_W   = $clog2(DEPTH);
  localparam logic [31:0]      SPAN    = 32'(DEPTH * 4);
  localparam logic [CNT_W-1:0] RD_LOAD = lat_load(READ_LATENCY);
  localparam logic [CNT_W-1:0] WR_LOAD = lat_load(WRITE_LATENCY);
  localparam logic [CNT_W-1:0] CNT_0   = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_1   = {{(CNT_W-1){1'b0}}, 1'b1};

  slave_state_t      state_r, state_s;
  mem_op_t           op_r, op_s;
  logic [CNT_W-1:0]  cnt_r, cnt_s, load_s;
  logic [IDX_W-1:0]  idx_r, idx_s;
  logic              oor_r, oor_s;
  logic [BE_W-1:0]   be_r, be_s;
  logic [WORD_W-1:0] wdat_r, wdat_s;
  logic              fire_s;

  logic read_ack_r, write_ack_r, busy_r, protocol_err_r, addr_err_r, zero_r;
  logic protocol_err_s, addr_err_s, zero_s;

  logic [31:0] offset_s;
  logic        in_range_s;

  logic              ram_re_s;
  logic [BE_W-1:0]   ram_we_s;
  logic [IDX_W-1:0]  ram_addr_s;
  logic [WORD_W-1:0] ram_wdata_s;
  logic [WORD_W-1:0] ram_rdata;

  // Unsigned offset from the base: anything below the base wraps high and
  // fails the same single range compare as anything above the top.
  assign offset_s   = address - BASE_ADDR;
  assign in_range_s = (offset_s < SPAN);

  // Next state, request capture, wait counter and sticky error flags.
  always_comb begin
    state_s        = state_r;
    op_s           = op_r;
    cnt_s          = cnt_r;
    idx_s          = idx_r;
    oor_s          = oor_r;
    be_s           = be_r;
    wdat_s         = wdat_r;
    protocol_err_s = protocol_err_r;
    addr_err_s     = addr_err_r;
    fire_s         = 1'b0;
    load_s         = RD_LOAD;
    case (state_r)
      IDLE, ACK: begin
        if (read_enable || write_enable) begin
          // Write wins when both strobes arrive together.
          if (write_enable) begin
            op_s   = MEM_WR;
            load_s = WR_LOAD;
          end else begin
            op_s   = MEM_RD;
            load_s = RD_LOAD;
          end
          if (read_enable && write_enable) begin
            protocol_err_s = 1'b1;
          end else begin
            protocol_err_s = protocol_err_r;
          end
          if (!in_range_s) begin
            addr_err_s = 1'b1;
          end else begin
            addr_err_s = addr_err_r;
          end
          idx_s  = offset_s[IDX_W+1:2];
          oor_s  = !in_range_s;
          be_s   = write_byte_enable;
          wdat_s = write_data;
          cnt_s  = load_s;
          if (load_s == CNT_0) begin
            state_s = ACK;
            fire_s  = 1'b1;
          end else begin
            state_s = WAIT;
            fire_s  = 1'b0;
          end
        end else begin
          state_s = IDLE;
          op_s    = MEM_NONE;
        end
      end
      WAIT: begin
        // Strobes here are dropped; the pending request carries on.
        if (read_enable || write_enable) begin
          protocol_err_s = 1'b1;
        end else begin
          protocol_err_s = protocol_err_r;
        end
        cnt_s = cnt_r - CNT_1;
        if (cnt_r == CNT_1) begin
          state_s = ACK;
          fire_s  = 1'b1;
        end else begin
          state_s = WAIT;
          fire_s  = 1'b0;
        end
      end
      default: begin
        state_s = IDLE;
        op_s    = MEM_NONE;
      end
    endcase
  end

  // Drive the RAM port on the edge that enters ACK. Reads must land then so
  // read_data is valid during read_ack. Writes also land then: nothing can
  // sample the array before that ack cycle ends, and it leaves the single port
  // free for a read accepted during write_ack. Reset blocks the access.
  always_comb begin
    ram_re_s    = 1'b0;
    ram_we_s    = {BE_W{1'b0}};
    ram_addr_s  = idx_s;
    ram_wdata_s = wdat_s;
    zero_s      = zero_r;
    if (fire_s && !rst) begin
      if (op_s == MEM_WR) begin
        if (oor_s) begin
          ram_we_s = {BE_W{1'b0}};
        end else begin
          ram_we_s = be_s;
        end
      end else begin
        if (oor_s) begin
          zero_s = 1'b1;
        end else begin
          ram_re_s = 1'b1;
          zero_s   = 1'b0;
        end
      end
    end else begin
      ram_re_s = 1'b0;
    end
  end

  // State, captured request and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r        <= IDLE;
      op_r           <= MEM_NONE;
      cnt_r          <= CNT_0;
      idx_r          <= {IDX_W{1'b0}};
      oor_r          <= 1'b0;
      be_r           <= {BE_W{1'b0}};
      wdat_r         <= {WORD_W{1'b0}};
      read_ack_r     <= 1'b0;
      write_ack_r    <= 1'b0;
      busy_r         <= 1'b0;
      protocol_err_r <= 1'b0;
      addr_err_r     <= 1'b0;
      zero_r         <= 1'b1;
    end else begin
      state_r        <= state_s;
      op_r           <= op_s;
      cnt_r          <= cnt_s;
      idx_r          <= idx_s;
      oor_r          <= oor_s;
      be_r           <= be_s;
      wdat_r         <= wdat_s;
      read_ack_r     <= (state_s == ACK) && (op_s == MEM_RD);
      write_ack_r    <= (state_s == ACK) && (op_s == MEM_WR);
      busy_r         <= (state_s == WAIT);
      protocol_err_r <= protocol_err_s;
      addr_err_r     <= addr_err_s;
      zero_r         <= zero_s;
    end
  end

  mem_array #(
    .DEPTH (DEPTH),
    .ADDR_W(IDX_W)
  ) u_mem_array (
    .clk  (clk),
    .re   (ram_re_s),
    .we   (ram_we_s),
    .addr (ram_addr_s),
    .wdata(ram_wdata_s),
    .rdata(ram_rdata)
  );

  // zero_r forces 0 after reset and after an out-of-range read.
  assign read_data    = zero_r ? {WORD_W{1'b0}} : ram_rdata;
  assign read_ack     = read_ack_r;
  assign write_ack    = write_ack_r;
  assign busy         = busy_r;
  assign protocol_err = protocol_err_r;
  assign addr_err     = addr_err_r;

endmodule

// File: tb/tb_data_mem_slave.sv
// Bench for data_mem_slave: three instances (default latencies with a
// non-zero base, read latency 1, read latency 5 / write latency 3).
// Expected acks are queued when a strobe is driven and checked when they appear.
module tb_data_mem_slave;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] address;
  logic [31:0] write_data;
  logic [3:0]  wbe;
  logic [2:0]  rd_en, wr_en;
  logic [31:0] rdata [3];
  logic [2:0]  rack, wack, busy, perr, aerr;

  int cyc   = 0;
  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    int          k;
    bit          rd;
    int          due;
    logic [31:0] data;
  } exp_t;

  exp_t        sb [$];
  logic [31:0] model [int];

  int          rl   [3] = '{2, 1, 5};
  int          wl   [3] = '{1, 1, 3};
  logic [31:0] base [3] = '{32'h0000_1000, 32'h0000_0000, 32'h0000_0000};
  logic [31:0] span [3] = '{32'h0000_1000, 32'h0000_0400, 32'h0000_0400};

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  data_mem_slave #(.DEPTH(1024), .BASE_ADDR(32'h0000_1000)) dut0 (
    .clk(clk), .rst(rst), .address(address), .read_enable(rd_en[0]),
    .write_enable(wr_en[0]), .write_byte_enable(wbe), .write_data(write_data),
    .read_data(rdata[0]), .read_ack(rack[0]), .write_ack(wack[0]),
    .busy(busy[0]), .protocol_err(perr[0]), .addr_err(aerr[0]));

  data_mem_slave #(.DEPTH(256), .BASE_ADDR(32'h0000_0000),
                   .READ_LATENCY(1), .WRITE_LATENCY(1)) dut1 (
    .clk(clk), .rst(rst), .address(address), .read_enable(rd_en[1]),
    .write_enable(wr_en[1]), .write_byte_enable(wbe), .write_data(write_data),
    .read_data(rdata[1]), .read_ack(rack[1]), .write_ack(wack[1]),
    .busy(busy[1]), .protocol_err(perr[1]), .addr_err(aerr[1]));

  data_mem_slave #(.DEPTH(256), .BASE_ADDR(32'h0000_0000),
                   .READ_LATENCY(5), .WRITE_LATENCY(3)) dut2 (
    .clk(clk), .rst(rst), .address(address), .read_enable(rd_en[2]),
    .write_enable(wr_en[2]), .write_byte_enable(wbe), .write_data(write_data),
    .read_data(rdata[2]), .read_ack(rack[2]), .write_ack(wack[2]),
    .busy(busy[2]), .protocol_err(perr[2]), .addr_err(aerr[2]));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_vec++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp_v, cyc);
    end
  endtask

  task automatic chk_idle(input int k);
    chk("rst_read_data", rdata[k], 32'h0);
    chk("rst_read_ack", {31'h0, rack[k]}, 32'h0);
    chk("rst_write_ack", {31'h0, wack[k]}, 32'h0);
    chk("rst_busy", {31'h0, busy[k]}, 32'h0);
    chk("rst_protocol_err", {31'h0, perr[k]}, 32'h0);
    chk("rst_addr_err", {31'h0, aerr[k]}, 32'h0);
  endtask

  // Drive a one-cycle strobe starting at the current negedge; if it should be
  // accepted, queue the expected ack and update the reference memory.
  task automatic issue(input int k, input bit r, input bit w, input logic [31:0] a,
                       input logic [3:0] be, input logic [31:0] d, input bit acc);
    exp_t        e;
    int          key;
    logic [31:0] cur;
    address    = a;
    wbe        = be;
    write_data = d;
    rd_en[k]   = r;
    wr_en[k]   = w;
    if (acc) begin
      e.k    = k;
      e.rd   = !w;
      e.due  = cyc + (w ? wl[k] : rl[k]);
      e.data = 32'h0;
      if (a >= base[k] && (a - base[k]) < span[k]) begin
        key = k * 65536 + int'((a - base[k]) >> 2);
        cur = model.exists(key) ? model[key] : 32'h0;
        if (w) begin
          for (int i = 0; i < 4; i++) begin
            if (be[i]) cur[8*i +: 8] = d[8*i +: 8];
          end
          model[key] = cur;
        end else begin
          e.data = cur;
        end
      end
      sb.push_back(e);
    end
    @(negedge clk);
    rd_en[k] = 1'b0;
    wr_en[k] = 1'b0;
  endtask

  task automatic wait_ready(input int k);
    for (int i = 0; i < 20 && busy[k] === 1'b1; i++) @(negedge clk);
    chk("ready_timeout", {31'h0, busy[k]}, 32'h0);
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && sb.size() != 0; i++) @(negedge clk);
    chk("drain_pending", sb.size(), 32'h0);
  endtask

  // Scoreboard: every ack must match the oldest queued expectation.
  always @(negedge clk) begin
    exp_t e;
    if (rst !== 1'b1) begin
      for (int k = 0; k < 3; k++) begin
        if (rack[k] === 1'b1 || wack[k] === 1'b1) begin
          chk("ack_expected", sb.size() != 0, 32'h1);
          if (sb.size() != 0) begin
            e = sb.pop_front();
            chk("ack_dut", k, e.k);
            chk("ack_kind", {30'h0, rack[k], wack[k]}, {30'h0, e.rd, !e.rd});
            chk("ack_cycle", cyc, e.due);
            if (e.rd) chk("read_data", rdata[k], e.data);
          end
        end
      end
      if (sb.size() != 0 && sb[0].due < cyc) begin
        chk("ack_missing_cycle", cyc, sb[0].due);
        void'(sb.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1, "timeout");
  end

  initial begin
    rst        = 1'b1;
    address    = 32'h0;
    write_data = 32'h0;
    wbe        = 4'h0;
    rd_en      = 3'b000;
    wr_en      = 3'b000;
    repeat (3) @(negedge clk);
    for (int k = 0; k < 3; k++) chk_idle(k);
    rst = 1'b0;
    @(negedge clk);

    // Write then read with default latencies; read accepted in write_ack cycle.
    issue(0, 1'b0, 1'b1, 32'h0000_1000, 4'hF, 32'hDEAD_BEEF, 1'b1);
    issue(0, 1'b1, 1'b0, 32'h0000_1000, 4'hF, 32'h0, 1'b1);
    drain();
    repeat (2) @(negedge clk);
    chk("read_data_hold", rdata[0], 32'hDEAD_BEEF);

    // Byte lanes and zero byte enable.
    issue(0, 1'b0, 1'b1, 32'h0000_1004, 4'hF, 32'h1122_3344, 1'b1);
    issue(0, 1'b0, 1'b1, 32'h0000_1004, 4'b0100, 32'h00AA_0000, 1'b1);
    issue(0, 1'b1, 1'b0, 32'h0000_1004, 4'hF, 32'h0, 1'b1);
    wait_ready(0);
    issue(0, 1'b0, 1'b1, 32'h0000_1004, 4'b0000, 32'hFFFF_FFFF, 1'b1);
    issue(0, 1'b1, 1'b0, 32'h0000_1004, 4'hF, 32'h0, 1'b1);
    drain();

    // Read latency 1: ack in the cycle right after the strobe, never busy.
    issue(1, 1'b0, 1'b1, 32'h0000_0040, 4'hF, 32'hCAFE_F00D, 1'b1);
    issue(1, 1'b1, 1'b0, 32'h0000_0040, 4'hF, 32'h0, 1'b1);
    chk("busy_rl1", {31'h0, busy[1]}, 32'h0);
    drain();

    // Read latency 5: busy for 4 cycles, low in the ack cycle.
    issue(2, 1'b0, 1'b1, 32'h0000_0080, 4'hF, 32'h0BAD_C0DE, 1'b1);
    wait_ready(2);
    issue(2, 1'b1, 1'b0, 32'h0000_0080, 4'hF, 32'h0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      chk("busy_rl5", {31'h0, busy[2]}, 32'h1);
      @(negedge clk);
    end
    chk("busy_rl5_ack", {31'h0, busy[2]}, 32'h0);
    drain();

    // Strobe during WAIT is rejected and flagged; original read completes.
    chk("perr_before", {31'h0, perr[2]}, 32'h0);
    issue(2, 1'b1, 1'b0, 32'h0000_0080, 4'hF, 32'h0, 1'b1);
    issue(2, 1'b1, 1'b0, 32'h0000_0084, 4'hF, 32'h0, 1'b0);
    chk("perr_wait", {31'h0, perr[2]}, 32'h1);
    drain();
    repeat (8) @(negedge clk);

    // Simultaneous read and write: write performed, single write_ack.
    chk("perr0_before", {31'h0, perr[0]}, 32'h0);
    issue(0, 1'b1, 1'b1, 32'h0000_1008, 4'hF, 32'h5A5A_5A5A, 1'b1);
    chk("perr_both", {31'h0, perr[0]}, 32'h1);
    issue(0, 1'b1, 1'b0, 32'h0000_1008, 4'hF, 32'h0, 1'b1);
    drain();

    // Out of range: read returns 0 on time, write does not alias word 0.
    chk("aerr_before", {31'h0, aerr[0]}, 32'h0);
    issue(0, 1'b1, 1'b0, 32'h0000_2000, 4'hF, 32'h0, 1'b1);
    drain();
    chk("aerr_after", {31'h0, aerr[0]}, 32'h1);
    issue(0, 1'b0, 1'b1, 32'h0000_2000, 4'hF, 32'hFFFF_FFFF, 1'b1);
    issue(0, 1'b1, 1'b0, 32'h0000_1000, 4'hF, 32'h0, 1'b1);
    drain();

    // Reset while a write waits: no ack, word unchanged, outputs cleared.
    issue(2, 1'b0, 1'b1, 32'h0000_0080, 4'hF, 32'h1234_5678, 1'b0);
    rst = 1'b1;
    sb.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk_idle(2);
    chk_idle(0);
    repeat (6) @(negedge clk);
    issue(2, 1'b1, 1'b0, 32'h0000_0080, 4'hF, 32'h0, 1'b1);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
